// File: rtl/rx_pkg.sv
// Shared constants and state encoding for the resource-element demapper.
package rx_pkg;
  localparam int NFFT       = 128;
  localparam int N_SC       = 12;
  localparam int N_SYM_SLOT = 7;
  localparam int PILOT_SYM  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } rdm_state_t;
endpackage

// File: rtl/rdm_sc_buffer.sv
// 12-entry indexed shadow of allocated subcarriers plus the copy-out vector register.
module rdm_sc_buffer
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [3:0]                     wr_idx,
  input  logic signed [2*DATA_WIDTH-1:0] wr_data,
  input  logic                           copy,
  output logic signed [2*DATA_WIDTH-1:0] out_vec [N_SC-1:0]
);

  logic signed [2*DATA_WIDTH-1:0] shadow [N_SC-1:0];

  // copy fires together with the write of the last slot, so that slot bypasses the shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_SC; j++) begin
        shadow[j]  <= '0;
        out_vec[j] <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_idx] <= wr_data;
      end
      if (copy) begin
        for (int j = 0; j < N_SC - 1; j++) begin
          out_vec[j] <= shadow[j];
        end
        out_vec[N_SC-1] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/res_demapper.sv
// Extracts the 12 allocated subcarriers of each SC-FDMA symbol from a serial FFT bin stream.
module res_demapper
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NFFT       = rx_pkg::NFFT,
  parameter int N_SYM_SLOT = rx_pkg::N_SYM_SLOT,
  parameter int PILOT_SYM  = rx_pkg::PILOT_SYM
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  input  logic signed [2*DATA_WIDTH-1:0] i_data,
  input  logic                           i_sof,
  input  logic                           i_slot_start,
  input  logic [6:0]                     i_sc_start,
  output logic signed [2*DATA_WIDTH-1:0] o_out_RDM [N_SC-1:0],
  output logic                           o_wen,
  output logic                           o_pilot,
  output logic [2:0]                     o_sym_idx,
  output logic                           o_err
);

  localparam logic [6:0] LAST_BIN = 7'(NFFT - 1);
  localparam logic [6:0] SC_MAX   = 7'(NFFT - N_SC);
  localparam logic [6:0] OFS_LAST = 7'(N_SC - 1);
  localparam logic [2:0] SYM_LAST = 3'(N_SYM_SLOT - 1);
  localparam logic [2:0] SYM_DMRS = 3'(PILOT_SYM);

  rdm_state_t state;
  logic [6:0] bin_cnt;
  logic [6:0] sc_reg;
  logic [2:0] sym_cnt;
  logic       started;

  logic       sof_acc;
  logic       sc_bad;
  logic [6:0] cur_bin;
  logic [6:0] cur_sc;
  logic [6:0] offset;
  logic       in_sym;
  logic       wr_en;
  logic       last_sc;

  // the bin on the sof cycle is bin 0 and uses the freshly presented sc_start
  assign sof_acc = i_valid && i_sof;
  assign sc_bad  = i_sc_start > SC_MAX;
  assign cur_bin = i_sof ? 7'd0 : bin_cnt + 7'd1;
  assign cur_sc  = i_sof ? i_sc_start : sc_reg;
  assign offset  = cur_bin - cur_sc;
  assign in_sym  = sof_acc ? !sc_bad : (i_valid && state == RECV);
  assign wr_en   = in_sym && (cur_bin >= cur_sc) && (offset <= OFS_LAST);
  assign last_sc = wr_en && (offset == OFS_LAST);

  rdm_sc_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .wr_en  (wr_en),
    .wr_idx (offset[3:0]),
    .wr_data(i_data),
    .copy   (last_sc),
    .out_vec(o_out_RDM)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      sc_reg    <= '0;
      sym_cnt   <= '0;
      started   <= 1'b0;
      o_wen     <= 1'b0;
      o_pilot   <= 1'b0;
      o_sym_idx <= '0;
      o_err     <= 1'b0;
    end else begin
      o_wen <= last_sc;
      o_err <= 1'b0;
      if (last_sc) begin
        o_sym_idx <= sym_cnt;
        o_pilot   <= (sym_cnt == SYM_DMRS);
      end
      if (sof_acc) begin
        bin_cnt <= '0;
        sc_reg  <= i_sc_start;
        started <= 1'b1;
        if (i_slot_start) begin
          sym_cnt <= '0;
        end else if (started) begin
          sym_cnt <= (sym_cnt == SYM_LAST) ? 3'd0 : sym_cnt + 3'd1;
        end
        // a bad allocation and a truncated previous symbol share one error pulse
        o_err <= sc_bad || (state == RECV && bin_cnt != LAST_BIN);
        state <= sc_bad ? DRAIN : RECV;
      end else if (i_valid) begin
        bin_cnt <= bin_cnt + 7'd1;
        if (state == RECV && cur_bin == LAST_BIN) begin
          state <= DRAIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_res_demapper.sv
// Directed table-driven bench for res_demapper with hand sequences for timing corners.
module tb_res_demapper;
  localparam int DW = 16;
  typedef logic signed [2*DW-1:0] cplx_t;
  typedef logic [11:0][2*DW-1:0] vec12_t;

  typedef struct packed {
    vec12_t     vec;
    logic       pilot;
    logic [2:0] sym;
  } cap_t;

  typedef struct {
    int sc; int slot; int salt; int nbins; int gaps;
    int wen; int err; int sym; int pilot;
  } tv_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_sof = 1'b0;
  logic       i_slot_start = 1'b0;
  cplx_t      i_data = '0;
  logic [6:0] i_sc_start = '0;
  cplx_t      o_out_RDM [11:0];
  logic       o_wen, o_pilot, o_err;
  logic [2:0] o_sym_idx;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_cnt = 0;
  cap_t cap_q[$];

  res_demapper #(.DATA_WIDTH(DW), .NFFT(128), .N_SYM_SLOT(7), .PILOT_SYM(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_sof(i_sof), .i_slot_start(i_slot_start), .i_sc_start(i_sc_start),
    .o_out_RDM(o_out_RDM), .o_wen(o_wen), .o_pilot(o_pilot),
    .o_sym_idx(o_sym_idx), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #1;
    if (o_wen) begin : grab
      cap_t c;
      for (int j = 0; j < 12; j++) c.vec[j] = o_out_RDM[j];
      c.pilot = o_pilot;
      c.sym   = o_sym_idx;
      cap_q.push_back(c);
    end
    if (o_err) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic cplx_t pat(input int k, input int salt);
    logic [DW-1:0] re;
    re = DW'(k + salt);
    return {re, -re};
  endfunction

  function automatic vec12_t live();
    vec12_t v;
    for (int j = 0; j < 12; j++) v[j] = o_out_RDM[j];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec12_t v, input int sc, input int salt, input int zero);
    int    bad;
    cplx_t e;
    bad = -1;
    for (int j = 0; j < 12; j++) begin
      e = (zero != 0) ? '0 : pat(sc + j, salt);
      if (v[j] !== e && bad < 0) bad = j;
    end
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      e = (zero != 0) ? '0 : pat(sc + bad, salt);
      $display("FAIL %s: element %0d got %h required %h", name, bad, v[bad], e);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic drive(input logic v, input logic sof, input logic slot, input int sc, input cplx_t d);
    i_valid = v; i_sof = sof; i_slot_start = slot; i_sc_start = 7'(sc); i_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      drive(1'b0, 1'b0, 1'b0, 0, '0);
    end
  endtask

  task automatic run_symbol(input int sc, input int slot, input int salt, input int nbins, input int gaps);
    for (int k = 0; k < nbins; k++) begin
      if (gaps != 0) begin : gap
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          tick();
          drive(1'b0, 1'b0, 1'b0, sc, '0);
        end
      end
      tick();
      drive(1'b1, k == 0, slot != 0, sc, pat(k, salt));
    end
  endtask

  tv_t tbl [10];
  int  e0;

  initial begin
    //        sc   slot salt nbins gaps wen err sym pilot
    tbl[0] = '{5,   1, 100, 128, 0,   1,  0,  0,  0};
    tbl[1] = '{116, 0, 200, 128, 0,   1,  0,  1,  0};
    tbl[2] = '{40,  0, 300, 128, 1,   1,  0,  2,  0};
    tbl[3] = '{40,  0, 300, 128, 0,   1,  0,  3,  1};
    tbl[4] = '{60,  0, 400, 50,  0,   0,  0,  4,  0};
    tbl[5] = '{60,  0, 500, 128, 0,   1,  1,  5,  0};
    tbl[6] = '{117, 0, 550, 128, 0,   0,  1,  6,  0};
    tbl[7] = '{0,   0, 600, 128, 0,   1,  0,  0,  0};
    tbl[8] = '{3,   1, 650, 128, 0,   1,  0,  0,  0};
    tbl[9] = '{64,  0, 680, 128, 0,   1,  0,  1,  0};

    // reset state
    idle(3);
    chk("rst_wen", int'(o_wen), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_pilot", int'(o_pilot), 0);
    chk("rst_sym", int'(o_sym_idx), 0);
    chk_vec("rst_vec", live(), 0, 0, 1);
    tick();
    i_rst_n = 1'b1;
    idle(2);

    // ramp at sc_start=0: latency, single-cycle pulse, drain, hold
    cap_q.delete();
    e0 = err_cnt;
    for (int k = 0; k < 12; k++) begin
      tick();
      drive(1'b1, k == 0, 1'b1, 0, pat(k, 0));
    end
    tick();
    chk("ramp_wen_latency", int'(o_wen), 1);
    chk_vec("ramp_vec_live", live(), 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, pat(12, 0));
    tick();
    chk("ramp_wen_one_cycle", int'(o_wen), 0);
    drive(1'b1, 1'b0, 1'b0, 0, pat(13, 0));
    for (int k = 14; k < 128; k++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 0, pat(k, 0));
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 0, pat(1000 + k, 0));
    end
    idle(3);
    chk("ramp_wen_count", cap_q.size(), 1);
    chk("ramp_err", err_cnt - e0, 0);
    chk_vec("ramp_vec_hold", live(), 0, 0, 0);
    if (cap_q.size() > 0) chk("ramp_sym", int'(cap_q[0].sym), 0);

    // table of whole symbols
    foreach (tbl[i]) begin
      cap_q.delete();
      e0 = err_cnt;
      run_symbol(tbl[i].sc, tbl[i].slot, tbl[i].salt, tbl[i].nbins, tbl[i].gaps);
      idle(3);
      chk($sformatf("tv%0d_wen_count", i), cap_q.size(), tbl[i].wen);
      chk($sformatf("tv%0d_err_count", i), err_cnt - e0, tbl[i].err);
      if (tbl[i].wen != 0 && cap_q.size() > 0) begin
        chk_vec($sformatf("tv%0d_vec", i), cap_q[0].vec, tbl[i].sc, tbl[i].salt, 0);
        chk($sformatf("tv%0d_sym", i), int'(cap_q[0].sym), tbl[i].sym);
        chk($sformatf("tv%0d_pilot", i), int'(cap_q[0].pilot), tbl[i].pilot);
      end
    end

    // bad sc_start: error pulse timing
    cap_q.delete();
    e0 = err_cnt;
    tick();
    drive(1'b1, 1'b1, 1'b1, 117, pat(0, 0));
    tick();
    chk("badsc_err_pulse", int'(o_err), 1);
    drive(1'b1, 1'b0, 1'b0, 117, pat(1, 0));
    tick();
    chk("badsc_err_one_cycle", int'(o_err), 0);
    for (int k = 2; k < 128; k++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 117, pat(k, 0));
    end
    idle(3);
    chk("badsc_no_wen", cap_q.size(), 0);
    chk("badsc_err_total", err_cnt - e0, 1);

    // sof landing in the o_wen cycle of the previous symbol
    cap_q.delete();
    e0 = err_cnt;
    run_symbol(116, 1, 700, 128, 0);
    run_symbol(20, 0, 800, 128, 0);
    idle(3);
    chk("b2b_wen_count", cap_q.size(), 2);
    chk("b2b_err", err_cnt - e0, 0);
    if (cap_q.size() == 2) begin
      chk_vec("b2b_vec0", cap_q[0].vec, 116, 700, 0);
      chk("b2b_sym0", int'(cap_q[0].sym), 0);
      chk_vec("b2b_vec1", cap_q[1].vec, 20, 800, 0);
      chk("b2b_sym1", int'(cap_q[1].sym), 1);
    end

    // reset in the middle of a symbol
    cap_q.delete();
    run_symbol(0, 0, 900, 6, 0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_vec("midrst_vec_zero", live(), 0, 0, 1);
    chk("midrst_wen", int'(o_wen), 0);
    chk("midrst_sym", int'(o_sym_idx), 0);
    idle(1);
    tick();
    i_rst_n = 1'b1;
    for (int k = 6; k < 128; k++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 0, pat(k, 900));
    end
    idle(3);
    chk("midrst_no_wen", cap_q.size(), 0);
    e0 = err_cnt;
    run_symbol(0, 0, 950, 128, 0);
    idle(3);
    chk("midrst_next_wen", cap_q.size(), 1);
    chk("midrst_next_err", err_cnt - e0, 0);
    if (cap_q.size() > 0) begin
      chk_vec("midrst_next_vec", cap_q[0].vec, 0, 950, 0);
      chk("midrst_next_sym", int'(cap_q[0].sym), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
